// File: rtl/int_dispatcher.sv
// Interrupt dispatcher: pending latch, priority pick, two-phase ack, timeout.
// Define INT_DISPATCHER_RR_EN for round-robin selection instead of fixed priority.
module int_dispatcher #(
  parameter int N              = 32,
  parameter int ID_WIDTH       = $clog2(N),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        irq_in,
  input  logic [N-1:0]        irq_mask,
  output logic                int_valid,
  output logic [ID_WIDTH-1:0] int_ID,
  input  logic                ack_start,
  input  logic [ID_WIDTH-1:0] ack_start_id,
  input  logic                ack_end,
  input  logic [ID_WIDTH-1:0] ack_end_id,
  output logic                busy,
  output logic [N-1:0]        pending,
  output logic                timeout_pulse,
  output logic [ID_WIDTH-1:0] timeout_id
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SVC  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N-1:0]        pend_q, pend_d;
  logic                tp_q, tp_d;
  logic [ID_WIDTH-1:0] tid_q, tid_d;

  logic [N-1:0]        elig;
  logic [N-1:0]        clr;
  logic [ID_WIDTH-1:0] start;
  logic [ID_WIDTH-1:0] sel_id;
  logic                sel_found;
  logic                expired;
  logic [CW-1:0]       cnt_dec;
  logic                done;
  int                  idx;

  assign elig    = pend_q & irq_mask;
  assign expired = (cnt_q == '0);
  assign cnt_dec = expired ? '0 : cnt_q - 1'b1;

  // Search wraps from start so one loop serves both selection modes.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(start) + i) % N;
      if (!sel_found && elig[idx]) begin
        sel_found = 1'b1;
        sel_id    = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    clr     = '0;
    tp_d    = 1'b0;
    tid_d   = tid_q;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d = S_REQ;
          id_d    = sel_id;
          cnt_d   = CW'(TIMEOUT_CYCLES - 1);
        end
      end
      S_REQ: begin
        cnt_d = cnt_dec;
        if (ack_start && ack_start_id == id_q) begin
          state_d = S_SVC;
        end else if (expired) begin
          state_d = S_IDLE;
          tp_d    = 1'b1;
          tid_d   = id_q;
        end
      end
      S_SVC: begin
        cnt_d = cnt_dec;
        if (ack_end && ack_end_id == id_q) begin
          state_d     = S_IDLE;
          clr[id_q]   = 1'b1;
          done        = 1'b1;
        end else if (expired) begin
          state_d = S_IDLE;
          tp_d    = 1'b1;
          tid_d   = id_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A new request on the clearing edge must survive.
    pend_d = (pend_q & ~clr) | irq_in;
  end

`ifdef INT_DISPATCHER_RR_EN
  logic [ID_WIDTH-1:0] ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (done) begin
      ptr_q <= (int'(id_q) == N - 1) ? '0 : id_q + 1'b1;
    end
  end

  assign start = ptr_q;
`else
  assign start = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      tp_q    <= 1'b0;
      tid_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      tp_q    <= tp_d;
      tid_q   <= tid_d;
    end
  end

  assign int_valid     = (state_q == S_REQ);
  assign busy          = (state_q != S_IDLE);
  assign int_ID        = id_q;
  assign pending       = pend_q;
  assign timeout_pulse = tp_q;
  assign timeout_id    = tid_q;

endmodule

// File: tb/tb_int_dispatcher.sv
// Bench for int_dispatcher: directed scenarios plus random traffic
// checked every cycle against a behavioural model.
module tb_int_dispatcher;

  localparam int N  = 32;
  localparam int IW = 5;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  irq_in = '0;
  logic [N-1:0]  irq_mask = '1;
  logic          int_valid;
  logic [IW-1:0] int_ID;
  logic          ack_start = 1'b0;
  logic [IW-1:0] ack_start_id = '0;
  logic          ack_end = 1'b0;
  logic [IW-1:0] ack_end_id = '0;
  logic          busy;
  logic [N-1:0]  pending;
  logic          timeout_pulse;
  logic [IW-1:0] timeout_id;

  int n_chk  = 0;
  int n_fail = 0;
  bit run_cmp = 1'b0;

  int_dispatcher #(.N(N), .ID_WIDTH(IW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .irq_in(irq_in), .irq_mask(irq_mask),
    .int_valid(int_valid), .int_ID(int_ID),
    .ack_start(ack_start), .ack_start_id(ack_start_id),
    .ack_end(ack_end), .ack_end_id(ack_end_id),
    .busy(busy), .pending(pending),
    .timeout_pulse(timeout_pulse), .timeout_id(timeout_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 offering, 2 in service; elapsed counts
  // edges since the offer was made.
  bit [N-1:0] m_pend;
  int m_phase, m_id, m_el, m_tid, m_ptr;
  bit m_tp;

  function automatic int pick(bit [N-1:0] e, int s);
    for (int k = 0; k < N; k++)
      if (e[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = '0; m_phase = 0; m_id = 0; m_el = 0;
      m_tid = 0; m_tp = 0; m_ptr = 0;
    end else begin
      bit [N-1:0] clrm;
      int p, s;
      clrm = '0;
      m_tp = 0;
`ifdef INT_DISPATCHER_RR_EN
      s = m_ptr;
`else
      s = 0;
`endif
      if (m_phase == 0) begin
        p = pick(m_pend & irq_mask, s);
        if (p >= 0) begin
          m_phase = 1; m_id = p; m_el = 0;
        end
      end else begin
        m_el++;
        if (m_phase == 1 && ack_start && int'(ack_start_id) == m_id) begin
          m_phase = 2;
        end else if (m_phase == 2 && ack_end && int'(ack_end_id) == m_id) begin
          clrm[m_id] = 1'b1;
          m_phase = 0;
          m_ptr = (m_id + 1) % N;
        end else if (m_el >= T) begin
          m_phase = 0; m_tp = 1; m_tid = m_id;
        end
      end
      m_pend = (m_pend & ~clrm) | irq_in;
    end
  end

  always @(posedge clk) begin
    #1;
    if (run_cmp) begin
      chk("valid", 32'(int_valid), 32'(m_phase == 1));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("int_ID", 32'(int_ID), 32'(m_id));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("tpulse", 32'(timeout_pulse), 32'(m_tp));
      chk("tid", 32'(timeout_id), 32'(m_tid));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [N-1:0] v);
    irq_in = v;
    cyc(1);
    irq_in = '0;
  endtask

  task automatic serve(input logic [IW-1:0] id);
    ack_start = 1'b1; ack_start_id = id;
    cyc(1);
    ack_start = 1'b0;
    ack_end = 1'b1; ack_end_id = id;
    cyc(1);
    ack_end = 1'b0;
  endtask

  initial begin
    int first, second;
    cyc(2);
    rst = 1'b0;
    run_cmp = 1'b1;
    cyc(1);
    chk("rst_valid", 32'(int_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pend", 32'(pending), 0);

    // single request
    pulse(32'h8);
    chk("s_pend", 32'(pending), 32'h8);
    chk("s_valid0", 32'(int_valid), 0);
    cyc(1);
    chk("s_valid1", 32'(int_valid), 1);
    chk("s_id", 32'(int_ID), 3);
    ack_start = 1'b1; ack_start_id = 5'd3;
    cyc(1);
    ack_start = 1'b0;
    chk("s_acc_v", 32'(int_valid), 0);
    chk("s_acc_b", 32'(busy), 1);
    ack_end = 1'b1; ack_end_id = 5'd3;
    cyc(1);
    ack_end = 1'b0;
    chk("s_end_p", 32'(pending), 0);
    chk("s_end_b", 32'(busy), 0);

    // priority
`ifdef INT_DISPATCHER_RR_EN
    first = 7; second = 2;
`else
    first = 2; second = 7;
`endif
    pulse(32'h84);
    cyc(1);
    chk("p_first", 32'(int_ID), 32'(first));
    serve(IW'(first));
    chk("p_gap", 32'(busy), 0);
    cyc(1);
    chk("p_second", 32'(int_ID), 32'(second));
    serve(IW'(second));
    cyc(1);

    // mask and mismatch
    irq_mask = ~(32'h20);
    pulse(32'h20);
    cyc(4);
    chk("m_busy", 32'(busy), 0);
    chk("m_pend", 32'(pending), 32'h20);
    irq_mask = '1;
    cyc(2);
    chk("m_id", 32'(int_ID), 5);
    ack_start = 1'b1; ack_start_id = 5'd4;
    cyc(1);
    ack_start = 1'b0;
    chk("m_mis", 32'(int_valid), 1);
    serve(5'd5);
    cyc(1);

    // timeout
    pulse(32'h200);
    cyc(1);
    chk("t_off", 32'(int_ID), 9);
    cyc(T - 1);
    chk("t_early", 32'(timeout_pulse), 0);
    cyc(1);
    chk("t_pulse", 32'(timeout_pulse), 1);
    chk("t_id", 32'(timeout_id), 9);
    chk("t_pend", 32'(pending[9]), 1);
    chk("t_busy", 32'(busy), 0);
    cyc(1);
    chk("t_reoff", 32'(int_valid), 1);
    chk("t_reid", 32'(int_ID), 9);
    serve(5'd9);
    cyc(1);

    // ack_end with new request for same source
    pulse(32'h40);
    cyc(1);
    ack_start = 1'b1; ack_start_id = 5'd6;
    cyc(1);
    ack_start = 1'b0;
    ack_end = 1'b1; ack_end_id = 5'd6; irq_in = 32'h40;
    cyc(1);
    ack_end = 1'b0; irq_in = '0;
    chk("c_pend", 32'(pending[6]), 1);
    cyc(1);
    chk("c_reoff", 32'(int_ID), 6);
    serve(5'd6);
    cyc(1);

    // ack_end on expiry edge
    pulse(32'h400);
    cyc(1);
    ack_start = 1'b1; ack_start_id = 5'd10;
    cyc(1);
    ack_start = 1'b0;
    cyc(T - 2);
    ack_end = 1'b1; ack_end_id = 5'd10;
    cyc(1);
    ack_end = 1'b0;
    chk("e_tp", 32'(timeout_pulse), 0);
    chk("e_busy", 32'(busy), 0);
    chk("e_pend", 32'(pending[10]), 0);
    cyc(1);

    // reset mid-service
    pulse(32'h2);
    cyc(1);
    ack_start = 1'b1; ack_start_id = 5'd1;
    cyc(1);
    ack_start = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("r_valid", 32'(int_valid), 0);
    chk("r_busy", 32'(busy), 0);
    chk("r_pend", 32'(pending), 0);
    chk("r_id", 32'(int_ID), 0);
    chk("r_tid", 32'(timeout_id), 0);
    cyc(1);
    rst = 1'b0;
    ack_end = 1'b1; ack_end_id = 5'd1;
    cyc(1);
    ack_end = 1'b0;
    chk("r_stray", 32'(busy), 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0)
        irq_mask = ($urandom_range(0, 1) == 0) ? '1 :
                   ~(32'h1 << $urandom_range(0, N - 1));
      irq_in = '0;
      if ($urandom_range(0, 3) == 0)
        irq_in = 32'h1 << $urandom_range(0, N - 1);
      if ($urandom_range(0, 9) == 0)
        irq_in = irq_in | (32'h1 << $urandom_range(0, N - 1));
      ack_start = ($urandom_range(0, 3) == 0);
      ack_start_id = ($urandom_range(0, 2) != 0) ? IW'(m_id)
                     : IW'($urandom_range(0, N - 1));
      ack_end = ($urandom_range(0, 3) == 0);
      ack_end_id = ($urandom_range(0, 2) != 0) ? IW'(m_id)
                   : IW'($urandom_range(0, N - 1));
      cyc(1);
    end
    irq_in = '0; ack_start = 1'b0; ack_end = 1'b0;
    cyc(2);
    run_cmp = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
